// File: rtl/jtag_dbg_pkg.sv
// Shared JTAG debug-path definitions: IR codes (common with the loader),
// fetch FSM state encoding and the default read address step.
package jtag_dbg_pkg;

    localparam logic [3:0] IR_CTRL   = 4'd0;
    localparam logic [3:0] IR_DATA   = 4'd2;
    localparam logic [3:0] IR_RADDR  = 4'd3;
    localparam logic [3:0] IR_RDATA  = 4'd4;
    localparam logic [3:0] IR_CLRERR = 4'd5;

    localparam int unsigned ADDR_STEP_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/jtag_readback_if.sv
// Memory read port between the readback block (master) and the memory (slave).
interface jtag_readback_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/rb_fetch.sv
// Single-outstanding req/ack fetch engine. A start accepted on the ack cycle
// chains straight into the next request without an idle gap.
module rb_fetch
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] addr,
    output logic          busy_c,
    output logic          done_c,
    output logic [DW-1:0] data_c,
    jtag_readback_if.master mem
);

    fetch_state_e  state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = addr;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    done_c = 1'b1;
                    if (start) begin
                        addr_d = addr;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign busy_c       = (state_q == REQ);
    assign data_c       = mem.mem_rdata;
    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

endmodule

// File: rtl/jtag_readback.sv
// JTAG readback: decodes synchronized IR updates and prefetches memory words
// with auto-increment so the next DR capture finds data already waiting.
module jtag_readback
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          upd,
    input  logic [3:0]    upd_ir,
    input  logic [DW-1:0] upd_dr,
    jtag_readback_if.master mem,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          overrun
);

    logic [AW-1:0] raddr, raddr_d;
    logic          pending;
    logic          discard;
    logic          is_raddr, is_rdata, is_clr, cmd_fetch;
    logic          eff_idle, keep, start;
    logic          busy_c, done_c;
    logic [DW-1:0] data_c;

    rb_fetch #(.AW(AW), .DW(DW)) u_fetch (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .addr   (raddr_d),
        .busy_c (busy_c),
        .done_c (done_c),
        .data_c (data_c),
        .mem    (mem)
    );

    // Ack is resolved before the command, so an ack cycle counts as idle.
    always_comb begin
        is_raddr  = upd && (upd_ir == IR_RADDR);
        is_rdata  = upd && (upd_ir == IR_RDATA);
        is_clr    = upd && (upd_ir == IR_CLRERR);
        cmd_fetch = is_raddr || is_rdata;
        eff_idle  = !busy_c || done_c;
        keep      = done_c && !discard;
        raddr_d   = raddr;
        if (keep) begin
            raddr_d = raddr + AW'(ADDR_STEP);
        end
        if (is_raddr) begin
            raddr_d = AW'(upd_dr);
        end
        start = (cmd_fetch && eff_idle) || (pending && !busy_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raddr    <= '0;
            pending  <= 1'b0;
            discard  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            raddr <= raddr_d;
            if (keep) begin
                rd_data  <= data_c;
                rd_valid <= 1'b1;
            end
            if (cmd_fetch) begin
                rd_valid <= 1'b0;
            end
            if (start) begin
                pending <= 1'b0;
            end else if (cmd_fetch) begin
                pending <= 1'b1;
            end
            // An address change mid-flight makes the outstanding word stale.
            if (is_raddr && !eff_idle) begin
                discard <= 1'b1;
            end else if (done_c) begin
                discard <= 1'b0;
            end
            if (is_rdata && !eff_idle) begin
                overrun <= 1'b1;
            end else if (is_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
